// File: rtl/e1_pkg.sv
// e1_pkg: shared types and helpers for the E1 arbiter slice.
//   E1            2-bit owner code: first=1, second=2, third=3
//   GRANT_NONE    code meaning "no owner"
//   arb_state_e   arbiter FSM states (IDLE, GRANT)
//   e1_onehot     E1 code -> request-vector bit mask
//   e1_next       cyclic successor (third wraps to first)
package e1_pkg;

    typedef logic [1:0] E1;

    localparam E1 GRANT_NONE = 2'd0;
    localparam E1 E1_FIRST   = 2'd1;
    localparam E1 E1_SECOND  = 2'd2;
    localparam E1 E1_THIRD   = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [2:0] e1_onehot(input E1 c);
        case (c)
            E1_FIRST:  e1_onehot = 3'b001;
            E1_SECOND: e1_onehot = 3'b010;
            E1_THIRD:  e1_onehot = 3'b100;
            default:   e1_onehot = 3'b000;
        endcase
    endfunction

    // GRANT_NONE also maps to first so a scan from "nobody" starts at first.
    function automatic E1 e1_next(input E1 c);
        case (c)
            E1_FIRST:  e1_next = E1_SECOND;
            E1_SECOND: e1_next = E1_THIRD;
            default:   e1_next = E1_FIRST;
        endcase
    endfunction

endpackage

// File: rtl/e1_rr_pick.sv
// e1_rr_pick: combinational round-robin pick among three E1 requesters.
//   req[2:0]    request vector (bit0=first, bit1=second, bit2=third)
//   start       last owner; the scan begins at its successor
//   exclude_en  when set, the requester named by exclude is ignored
//   exclude     E1 code to drop from the scan
//   pick        winning E1 code (GRANT_NONE when nothing requests)
//   pick_valid  a winner exists
module e1_rr_pick
    import e1_pkg::*;
(
    input  logic [2:0] req,
    input  E1          start,
    input  logic       exclude_en,
    input  E1          exclude,
    output E1          pick,
    output logic       pick_valid
);

    logic [2:0] w_req;
    E1          w_scan;

    always_comb begin
        w_req      = req & ~(exclude_en ? e1_onehot(exclude) : 3'b000);
        w_scan     = start;
        pick       = GRANT_NONE;
        pick_valid = 1'b0;
        // Three steps cover every requester once, starting after 'start'.
        for (int i = 0; i < 3; i++) begin
            w_scan = e1_next(w_scan);
            if (!pick_valid && ((w_req & e1_onehot(w_scan)) != 3'b000)) begin
                pick       = w_scan;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/e1_arbiter.sv
// e1_arbiter: round-robin owner arbiter for one E1-coded resource shared by
// three requesters. Owner handover is back-to-back on release.
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[2:0]     request vector (bit0=first, bit1=second, bit2=third)
//   done         owner releases the resource (ignored while idle)
//   grant        registered owner code, GRANT_NONE when idle
//   grant_valid  registered, high while a tenure is active
//   timeout      one-cycle pulse when a tenure was force-ended
// Optional feature: define E1_ARBITER_TIMEOUT_EN to bound tenure to
// TIMEOUT_CYCLES cycles; otherwise timeout is tied low and no counter exists.
module e1_arbiter
    import e1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       done,
    output E1          grant,
    output logic       grant_valid,
    output logic       timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("e1_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_e r_state, w_state_nxt;
    E1          r_last,  w_last_nxt;
    E1          r_grant, w_grant_nxt;
    logic       r_gv,    w_gv_nxt;

    E1          w_pick;
    logic       w_pick_valid;
    logic       w_own_req;
    logic       w_expire;
    logic       w_end;

    // In GRANT, r_last is the owner; excluding it makes pick_valid mean
    // "somebody else is waiting", which is exactly the handover condition.
    e1_rr_pick u_pick (
        .req        (req),
        .start      (r_last),
        .exclude_en (r_state == GRANT),
        .exclude    (r_last),
        .pick       (w_pick),
        .pick_valid (w_pick_valid)
    );

    assign w_own_req = (req & e1_onehot(r_last)) != 3'b000;
    // A dropped request is an implicit release.
    assign w_end     = done || !w_own_req || w_expire;

`ifdef E1_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          r_to;
    logic          w_to_nxt;

    assign w_expire = (r_state == GRANT) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    // Pulse only when the timer alone ended the tenure; a same-cycle done or
    // dropped request is an ordinary release.
    assign w_to_nxt = w_expire && !done && w_own_req;

    // Every tenure end (handover, re-win or idle) restarts the count, so the
    // expire compare fires before the counter could wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            r_cnt <= (r_state == GRANT && !w_end) ? r_cnt + CW'(1) : '0;
            r_to  <= w_to_nxt;
        end
    end

    assign timeout = r_to;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_gv_nxt    = r_gv;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_last_nxt  = w_pick;
                    w_grant_nxt = w_pick;
                    w_gv_nxt    = 1'b1;
                end
            end
            GRANT: begin
                if (w_end) begin
                    if (w_pick_valid) begin
                        w_last_nxt  = w_pick;
                        w_grant_nxt = w_pick;
                    end else if (w_own_req && (done || w_expire)) begin
                        // Sole requester re-wins; outputs unchanged.
                        w_grant_nxt = r_last;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = GRANT_NONE;
                        w_gv_nxt    = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = GRANT_NONE;
                w_gv_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= E1_THIRD;
            r_grant <= GRANT_NONE;
            r_gv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_gv    <= w_gv_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_gv;

endmodule

// File: tb/tb_e1_arbiter.sv
// tb_e1_arbiter: directed self-checking bench for e1_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// i.e. after the edge that consumed the previous input values.
// Define E1_ARBITER_TIMEOUT_EN to add the tenure-timeout steps.
module tb_e1_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       done;
    logic [1:0] grant;
    logic       grant_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    e1_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Checks grant, grant_valid and timeout together.
    task automatic chk_out(input string tag, input logic [1:0] g, input logic v, input logic t);
        chk({tag, ".grant"}, {6'd0, grant}, {6'd0, g});
        chk({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, v});
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        done  = 1'b0;
        #3;
        chk_out("reset", 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("idle_after_reset", 2'd0, 1'b0, 1'b0);

        // All request: first wins after reset, then rotate on each done.
        req = 3'b111;
        tick();
        chk_out("rr_first", 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("rr_second", 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("rr_third", 2'd3, 1'b1, 1'b0);
        tick();
        chk_out("rr_wrap_first", 2'd1, 1'b1, 1'b0);
        done = 1'b0;
        tick();
        chk_out("rr_hold", 2'd1, 1'b1, 1'b0);

        // Owner first drops its request: immediate handover to second.
        req = 3'b010;
        tick();
        chk_out("drop_handover", 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("sole_hold", 2'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("sole_rewin", 2'd2, 1'b1, 1'b0);
        done = 1'b0;

        // Move to first, then drop everything -> idle; done in idle ignored.
        req = 3'b001;
        tick();
        chk_out("to_first", 2'd1, 1'b1, 1'b0);
        req = 3'b000;
        tick();
        chk_out("to_idle", 2'd0, 1'b0, 1'b0);
        done = 1'b1;
        tick();
        chk_out("done_in_idle", 2'd0, 1'b0, 1'b0);
        done = 1'b0;

        // Third takes over, then async reset mid-tenure.
        req = 3'b100;
        tick();
        chk_out("third_owner", 2'd3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 2'd0, 1'b0, 1'b0);
        req = 3'b101;
        #2;
        rst_n = 1'b1;
        tick();
        chk_out("post_reset_first", 2'd1, 1'b1, 1'b0);

        // Pick order from various last owners.
        req  = 3'b110;
        done = 1'b1;
        tick();
        chk_out("pick_after_first", 2'd2, 1'b1, 1'b0);
        req = 3'b101;
        tick();
        chk_out("pick_after_second", 2'd3, 1'b1, 1'b0);
        tick();
        chk_out("pick_after_third", 2'd1, 1'b1, 1'b0);
        req  = 3'b000;
        done = 1'b0;
        tick();
        chk_out("idle_again", 2'd0, 1'b0, 1'b0);

`ifdef E1_ARBITER_TIMEOUT_EN
        // Timeout: each owner holds 4 cycles, handover pulses timeout.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 3'b011;
        tick();
        chk_out("to_first_c0", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to_first_c1", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to_first_c2", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to_first_c3", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to_second_pulse", 2'd2, 1'b1, 1'b1);
        tick();
        chk_out("to_second_c1", 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("to_second_c2", 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("to_second_c3", 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("to_first_pulse", 2'd1, 1'b1, 1'b1);
        tick();
        chk_out("to_first_b_c1", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to_first_b_c2", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("to_first_b_c3", 2'd1, 1'b1, 1'b0);
        // done coincides with counter at 3: plain handover, no pulse.
        done = 1'b1;
        tick();
        chk_out("done_at_expire", 2'd2, 1'b1, 1'b0);
        done = 1'b0;
        req  = 3'b000;
        tick();
        chk_out("to_idle_end", 2'd0, 1'b0, 1'b0);
`else
        // Without the timeout feature tenure is unbounded.
        req = 3'b011;
        tick();
        chk_out("unbounded_start", 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk_out("unbounded_hold", 2'd2, 1'b1, 1'b0);
        req = 3'b000;
        tick();
        chk_out("unbounded_idle", 2'd0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e1_arbiter.md
# e1_arbiter

Round-robin arbiter that shares one E1-coded resource between three requesters and publishes the current owner as an E1 value. It sits in front of the E1 pass-through datapath and drives the E1 select input. The block sequences ownership with a request/done handshake and back-to-back handover. An optional tenure timeout bounds how long any one owner can hold the resource.

## Interface
- TIMEOUT_CYCLES, 16: maximum tenure in cycles, used only with the timeout feature. Legal range is 2..65535.
- clk  input  1  clock; all flops are rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  3  request vector; bit0 ↔ first, bit1 ↔ second, bit2 ↔ third.
- done  input  1  current owner releases the resource; sampled only while grant_valid=1.
- grant  output  E1 (2)  current owner code: first=1, second=2, third=3. Value 2'd0 (GRANT_NONE) means no owner.
- grant_valid  output  1  high while a tenure is active.
- timeout  output  1  one-cycle pulse when a tenure is force-ended.

## Operation
- Two states:
  - IDLE: grant=GRANT_NONE, grant_valid=0.
  - GRANT: grant=owner, grant_valid=1.
- last_owner register resets to third, so first wins the first arbitration after reset.
- Pick rule: the first set req bit, scanning cyclically from last_owner+1, wrapping third→first.
- IDLE → GRANT: any req bit set. The picked requester becomes owner, and last_owner is updated to it.
- GRANT, end of tenure: done=1, or req[owner]=0 (a dropped request counts as an implicit release).
  - If any req bit other than the owner's is set: hand over on the same edge to the next pick. The cycle stays in GRANT, with no idle cycle.
  - Else if req[owner] is still set and done=1: the owner re-wins.
  - Else: go to IDLE.
- GRANT with no release: hold owner; grant is stable.
- done while in IDLE: ignored.
- req bits may change on any cycle. Only values at the arbitration edge matter.

## Timing
- Registered outputs. req rising in cycle k → grant/grant_valid updated in cycle k+1.
- Handover: done in cycle k → new owner visible in cycle k+1.
- Reset values: grant=GRANT_NONE, grant_valid=0, timeout=0, state=IDLE, last_owner=third, tenure counter=0.
- Reset asserted mid-tenure clears all outputs immediately, without waiting for a clock edge.
- Tenure counter:
  - Width is $clog2(TIMEOUT_CYCLES).
  - Cleared on every grant or handover; increments each GRANT cycle.
  - Saturation is never reached, because forced release occurs at count TIMEOUT_CYCLES-1.

## Configuration
- Macro: E1_ARBITER_TIMEOUT_EN.
- Defined:
  - In GRANT, when the counter reaches TIMEOUT_CYCLES-1 without done, the tenure ends as if done=1.
  - The handover rule applies, except the timed-out owner may re-win only if no other req bit is set.
  - timeout pulses high for exactly the cycle in which the new grant (or IDLE) first appears.
  - done and timeout in the same cycle: treated as done, no timeout pulse.
- Undefined:
  - No counter is built, and TIMEOUT_CYCLES is unused.
  - timeout is tied to 0; the port remains present.
  - Tenure is unbounded.

## Structure
- Shared package e1_pkg holds:
  - typedef E1 (logic [1:0]: first=1, second=2, third=3);
  - constant GRANT_NONE = 2'd0;
  - arbiter state enum (IDLE, GRANT).
- Sub-module e1_rr_pick: purely combinational.
  - Inputs: req[2:0], start E1 (last_owner), exclude_en, exclude E1.
  - Outputs: pick E1, pick_valid.
  - Instantiated once; the top holds the state machine, registers and timeout counter.

## Test plan
- Reset, then req=3'b111 held → grant sequence first, second, third, first on successive done pulses, one owner per done, no idle cycles.
- req=3'b010 only; done in cycle 5 with req still 3'b010 → second re-granted, grant_valid stays 1, grant stays 2.
- Owner first; req becomes 3'b000 in cycle 4 → grant_valid=0 and grant=0 in cycle 5. done while idle → no change.
- rst_n pulled low during the third's tenure → grant=0 and grant_valid=0 asynchronously. After release with req=3'b101 → first wins.
- With E1_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, req=3'b011, done never asserted:
  - first held 4 cycles, then second;
  - timeout=1 for one cycle at each handover.
- With E1_ARBITER_TIMEOUT_EN, done asserted in the same cycle the counter hits 3 → handover with timeout=0.
